// File: rtl/wordle_guess_engine_if.sv
// Bus between the Wordle guess engine and the board top: target, letter entry and score outputs.
interface wordle_guess_engine_if #(
  parameter int unsigned WORD_LEN  = 5,
  parameter int unsigned CHAR_W    = 5,
  parameter int unsigned MAX_GUESS = 6
);
  localparam int unsigned PosW  = $clog2(WORD_LEN + 1);
  localparam int unsigned GnumW = $clog2(MAX_GUESS + 1);

  logic                         target_load;
  logic [WORD_LEN*CHAR_W-1:0]   target_word;
  logic [CHAR_W-1:0]            char_in;
  logic                         enter;
  logic                         backspace;
  logic [WORD_LEN*CHAR_W-1:0]   guess_word;
  logic [PosW-1:0]              pos;
  logic [GnumW-1:0]             guess_num;
  logic [2*WORD_LEN-1:0]        result;
  logic                         result_valid;
  logic                         bad_char;
  logic                         q_I;
  logic                         q_Entry;
  logic                         q_Eval;
  logic                         q_Wrong;
  logic                         q_Correct;
  logic                         q_Done;

  modport master (
    output target_load, target_word, char_in, enter, backspace,
    input  guess_word, pos, guess_num, result, result_valid, bad_char,
    input  q_I, q_Entry, q_Eval, q_Wrong, q_Correct, q_Done
  );

  modport slave (
    input  target_load, target_word, char_in, enter, backspace,
    output guess_word, pos, guess_num, result, result_valid, bad_char,
    output q_I, q_Entry, q_Eval, q_Wrong, q_Correct, q_Done
  );
endinterface

// File: rtl/wordle_guess_engine.sv
// Wordle core: letter entry into a guess register, multi-cycle green/yellow scoring with
// duplicate-letter consumption, and guess counting up to MAX_GUESS.
module wordle_guess_engine #(
  parameter int unsigned WORD_LEN  = 5,
  parameter int unsigned CHAR_W    = 5,
  parameter int unsigned MAX_GUESS = 6,
  parameter int unsigned ALPHA     = 26
) (
  input logic                  sys_clk,
  input logic                  Reset,
  wordle_guess_engine_if.slave io_bus
);
  localparam int unsigned PosW  = $clog2(WORD_LEN + 1);
  localparam int unsigned GnumW = $clog2(MAX_GUESS + 1);
  localparam int unsigned WordW = WORD_LEN * CHAR_W;
  localparam logic [2*WORD_LEN-1:0] AllGreen = {WORD_LEN{2'b10}};

  typedef enum logic [2:0] {StI, StEntry, StEval, StWrong, StCorrect, StDone} state_e;

  state_e                r_state;
  logic [WordW-1:0]      r_target;
  logic [WordW-1:0]      r_guess;
  logic [PosW-1:0]       r_pos;
  logic [PosW-1:0]       r_idx;
  logic [GnumW-1:0]      r_gnum;
  logic [2*WORD_LEN-1:0] r_result;
  logic [2*WORD_LEN-1:0] r_work;
  logic [WORD_LEN-1:0]   r_cons;
  logic                  r_valid;
  logic                  r_bad;

  logic [2*WORD_LEN-1:0] w_green_res;
  logic [WORD_LEN-1:0]   w_green_cons;
  logic [2*WORD_LEN-1:0] w_step_res;
  logic [WORD_LEN-1:0]   w_step_cons;
  logic                  w_found;
  logic [GnumW-1:0]      w_gnum_inc;
  logic                  w_char_ok;

  assign w_char_ok  = (io_bus.char_in != '0) && (io_bus.char_in <= CHAR_W'(ALPHA));
  assign w_gnum_inc = (r_gnum == GnumW'(MAX_GUESS)) ? r_gnum : r_gnum + GnumW'(1);

  always_comb begin
    w_green_res  = '0;
    w_green_cons = '0;
    for (int i = 0; i < WORD_LEN; i++) begin
      if (r_guess[i*CHAR_W +: CHAR_W] == r_target[i*CHAR_W +: CHAR_W]) begin
        w_green_cons[i]      = 1'b1;
        w_green_res[2*i +: 2] = 2'b10;
      end
    end
  end

  // Yellow step for guess position r_idx-1: claim the lowest unconsumed matching target slot.
  always_comb begin
    w_step_res  = r_work;
    w_step_cons = r_cons;
    w_found     = 1'b0;
    for (int k = 0; k < WORD_LEN; k++) begin
      if (r_idx == PosW'(k + 1) && !r_work[2*k+1]) begin
        for (int j = 0; j < WORD_LEN; j++) begin
          if (!w_found && !r_cons[j] &&
              r_target[j*CHAR_W +: CHAR_W] == r_guess[k*CHAR_W +: CHAR_W]) begin
            w_found              = 1'b1;
            w_step_cons[j]       = 1'b1;
            w_step_res[2*k +: 2] = 2'b01;
          end
        end
      end
    end
  end

  always_ff @(posedge sys_clk or posedge Reset) begin
    if (Reset) begin
      r_state  <= StI;
      r_target <= '0;
      r_guess  <= '0;
      r_pos    <= '0;
      r_idx    <= '0;
      r_gnum   <= '0;
      r_result <= '0;
      r_work   <= '0;
      r_cons   <= '0;
      r_valid  <= 1'b0;
      r_bad    <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_bad   <= 1'b0;
      case (r_state)
        StI: begin
          if (io_bus.target_load) begin
            r_target <= io_bus.target_word;
            r_gnum   <= '0;
            r_pos    <= '0;
            r_guess  <= '0;
            r_result <= '0;
            r_state  <= StEntry;
          end
        end
        StEntry: begin
          if (io_bus.enter) begin
            if (r_pos < PosW'(WORD_LEN)) begin
              if (w_char_ok) begin
                for (int i = 0; i < WORD_LEN; i++) begin
                  if (r_pos == PosW'(i)) r_guess[i*CHAR_W +: CHAR_W] <= io_bus.char_in;
                end
                r_pos <= r_pos + PosW'(1);
              end else begin
                r_bad <= 1'b1;
              end
            end else begin
              r_idx   <= '0;
              r_state <= StEval;
            end
          end else if (io_bus.backspace && r_pos != '0) begin
            for (int i = 0; i < WORD_LEN; i++) begin
              if (r_pos == PosW'(i + 1)) r_guess[i*CHAR_W +: CHAR_W] <= '0;
            end
            r_pos <= r_pos - PosW'(1);
          end
        end
        StEval: begin
          if (r_idx == '0) begin
            r_work <= w_green_res;
            r_cons <= w_green_cons;
            r_idx  <= PosW'(1);
          end else begin
            r_work <= w_step_res;
            r_cons <= w_step_cons;
            if (r_idx == PosW'(WORD_LEN)) begin
              r_result <= w_step_res;
              r_valid  <= 1'b1;
              r_gnum   <= w_gnum_inc;
              if (w_step_res == AllGreen)              r_state <= StCorrect;
              else if (w_gnum_inc == GnumW'(MAX_GUESS)) r_state <= StDone;
              else                                      r_state <= StWrong;
            end else begin
              r_idx <= r_idx + PosW'(1);
            end
          end
        end
        StWrong: begin
          if (io_bus.enter) begin
            r_pos   <= '0;
            r_guess <= '0;
            r_state <= StEntry;
          end
        end
        StCorrect, StDone: begin
          if (io_bus.enter) r_state <= StI;
        end
        default: r_state <= StI;
      endcase
    end
  end

  assign io_bus.guess_word   = r_guess;
  assign io_bus.pos          = r_pos;
  assign io_bus.guess_num    = r_gnum;
  assign io_bus.result       = r_result;
  assign io_bus.result_valid = r_valid;
  assign io_bus.bad_char     = r_bad;
  assign io_bus.q_I          = (r_state == StI);
  assign io_bus.q_Entry      = (r_state == StEntry);
  assign io_bus.q_Eval       = (r_state == StEval);
  assign io_bus.q_Wrong      = (r_state == StWrong);
  assign io_bus.q_Correct    = (r_state == StCorrect);
  assign io_bus.q_Done       = (r_state == StDone);
endmodule

// File: tb/tb_wordle_guess_engine.sv
// Directed bench for wordle_guess_engine: entry, scoring, duplicates, win, loss, reset mid-Eval.
module tb_wordle_guess_engine;
  localparam logic [5:0] SI = 6'b000001, SEntry = 6'b000010, SEval = 6'b000100;
  localparam logic [5:0] SWrong = 6'b001000, SCorrect = 6'b010000, SDone = 6'b100000;

  logic sys_clk = 1'b0;
  logic Reset   = 1'b1;
  int   n_total = 0;
  int   n_bad   = 0;
  int   bad_seen = 0;

  wordle_guess_engine_if #(.WORD_LEN(5), .CHAR_W(5), .MAX_GUESS(6)) bus ();

  wordle_guess_engine #(.WORD_LEN(5), .CHAR_W(5), .MAX_GUESS(6), .ALPHA(26)) dut (
    .sys_clk (sys_clk),
    .Reset   (Reset),
    .io_bus  (bus)
  );

  always #5 sys_clk = ~sys_clk;

  function automatic logic [24:0] mk(input logic [4:0] a, b, c, d, e);
    return {e, d, c, b, a};
  endfunction

  function automatic logic [5:0] st();
    return {bus.q_Done, bus.q_Correct, bus.q_Wrong, bus.q_Eval, bus.q_Entry, bus.q_I};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic press(input logic [4:0] c, input logic bs);
    @(negedge sys_clk);
    bus.char_in   = c;
    bus.enter     = 1'b1;
    bus.backspace = bs;
    @(negedge sys_clk);
    bus.enter     = 1'b0;
    bus.backspace = 1'b0;
    if (bus.bad_char) bad_seen++;
  endtask

  task automatic bksp();
    @(negedge sys_clk);
    bus.backspace = 1'b1;
    @(negedge sys_clk);
    bus.backspace = 1'b0;
  endtask

  task automatic load(input logic [24:0] w);
    @(negedge sys_clk);
    bus.target_word = w;
    bus.target_load = 1'b1;
    @(negedge sys_clk);
    bus.target_load = 1'b0;
  endtask

  task automatic type_word(input logic [24:0] w);
    for (int i = 0; i < 5; i++) press(w[i*5 +: 5], 1'b0);
  endtask

  task automatic play(input logic [24:0] w, input logic [9:0] exp_res, input logic [2:0] exp_n,
                      input logic [5:0] exp_st, input string tag);
    int lat;
    type_word(w);
    press(5'd0, 1'b0);
    lat = 0;
    while (!bus.result_valid && lat < 20) begin
      @(negedge sys_clk);
      lat++;
    end
    chk({tag, "_lat"}, lat, 6);
    chk({tag, "_res"}, bus.result, exp_res);
    chk({tag, "_gnum"}, bus.guess_num, exp_n);
    chk({tag, "_st"}, st(), exp_st);
    @(negedge sys_clk);
    chk({tag, "_vpulse"}, bus.result_valid, 0);
  endtask

  logic [24:0] apple, paper, ppppp, eeeee;
  logic [24:0] g_words [6];
  logic [9:0]  g_res   [6];

  initial begin
    apple = mk(1, 16, 16, 12, 5);
    paper = mk(16, 1, 16, 5, 18);
    ppppp = mk(16, 16, 16, 16, 16);
    eeeee = mk(5, 5, 5, 5, 5);
    bus.target_load = 1'b0;
    bus.target_word = '0;
    bus.char_in     = '0;
    bus.enter       = 1'b0;
    bus.backspace   = 1'b0;
    repeat (2) @(negedge sys_clk);
    Reset = 1'b0;
    chk("rst_st", st(), SI);
    chk("rst_out", {bus.pos, bus.guess_num, bus.result, bus.result_valid, bus.bad_char}, 0);
    chk("rst_guess", bus.guess_word, 0);

    press(5'd5, 1'b0);
    chk("idle_enter_st", st(), SI);
    load(apple);
    chk("load_st", st(), SEntry);

    press(5'd3, 1'b0); press(5'd0, 1'b0); press(5'd1, 1'b0);
    press(5'd27, 1'b0); press(5'd20, 1'b0);
    chk("entry_bad", bad_seen, 2);
    chk("entry_pos", bus.pos, 3);
    chk("entry_guess", bus.guess_word, mk(3, 1, 20, 0, 0));

    bksp();
    chk("bs_pos", bus.pos, 2);
    chk("bs_clear", bus.guess_word, mk(3, 1, 0, 0, 0));
    press(5'd20, 1'b1);
    chk("ent_bs_pos", bus.pos, 3);
    chk("ent_bs_guess", bus.guess_word, mk(3, 1, 20, 0, 0));
    repeat (3) bksp();
    bksp();
    chk("bs_zero_pos", bus.pos, 0);
    chk("bs_zero_guess", bus.guess_word, 0);

    play(paper, 10'b00_01_10_01_01, 3'd1, SWrong, "paper");
    press(5'd0, 1'b0);
    chk("wrong_st", st(), SEntry);
    chk("wrong_clr", {bus.pos, bus.guess_word}, 0);
    play(apple, 10'b10_10_10_10_10, 3'd2, SCorrect, "win");
    press(5'd0, 1'b0);
    chk("win_exit", st(), SI);

    load(apple);
    g_words = '{ppppp, eeeee, paper, ppppp, eeeee, paper};
    g_res   = '{10'b00_00_10_10_00, 10'b10_00_00_00_00, 10'b00_01_10_01_01,
                10'b00_00_10_10_00, 10'b10_00_00_00_00, 10'b00_01_10_01_01};
    for (int g = 0; g < 6; g++) begin
      play(g_words[g], g_res[g], 3'(g + 1), (g == 5) ? SDone : SWrong, "loss");
      if (g < 5) press(5'd0, 1'b0);
    end
    load(eeeee);
    chk("done_load_ign", st(), SDone);
    chk("done_gnum", bus.guess_num, 6);
    press(5'd0, 1'b0);
    chk("done_exit", st(), SI);

    load(apple);
    type_word(paper);
    press(5'd0, 1'b0);
    repeat (2) @(negedge sys_clk);
    chk("eval_st", st(), SEval);
    #2 Reset = 1'b1;
    #1;
    chk("mid_rst_st", st(), SI);
    chk("mid_rst_out", {bus.pos, bus.guess_num, bus.result, bus.result_valid, bus.bad_char}, 0);
    chk("mid_rst_guess", bus.guess_word, 0);
    @(negedge sys_clk);
    Reset = 1'b0;

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
